receptor_serial_paridade: RTL and testbench

Serial front end for the parity-check path: recovers frames from an asynchronous 1-wire line and presents each one as an 8-bit data byte plus its received parity bit. The line format is start, 8 data bits LSB-first, parity, stop. The outputs `dados` and `bit_paridade` drive the parity checker directly, and that checker uses odd parity. `valido` marks each new byte. `erro_quadro` flags frames with a bad stop bit.

---
 rtl/receptor_serial_pkg.sv | 16 +
 rtl/sincronizador_rx.sv | 25 ++
 rtl/receptor_serial_paridade.sv | 117 +++++++++++
 tb/tb_receptor_serial_paridade.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/receptor_serial_pkg.sv
// Shared types and constants for the serial receiver of the parity-check path.
// Frame format: start, 8 data bits LSB-first, parity, stop.
package receptor_serial_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_t;

    localparam int   BITS_DADOS   = 8;
    localparam logic NIVEL_OCIOSO = 1'b1;

endpackage

// File: rtl/sincronizador_rx.sv
// Two-flop synchronizer for the asynchronous rx line, reset to the idle level.
// Latency: 2 cycles. Backpressure: none, samples every cycle.
// Used by the receiver only when RX_SINCRONIZADOR_EN is defined.
module sincronizador_rx
    import receptor_serial_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= NIVEL_OCIOSO;
            q    <= NIVEL_OCIOSO;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/receptor_serial_paridade.sv
// Serial receiver: start + 8 data (LSB first) + parity + stop -> dados/bit_paridade.
// Latency: valido/erro_quadro one cycle after the stop-bit sample (e0+N/2+10N), +2 with RX_SINCRONIZADOR_EN.
// Backpressure: none; the line cannot be stalled, each frame is presented once with a one-cycle pulse.
module receptor_serial_paridade
    import receptor_serial_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [BITS_DADOS-1:0] dados,
    output logic                  bit_paridade,
    output logic                  valido,
    output logic                  erro_quadro,
    output logic                  ocupado
);

    localparam int CW = $clog2(CICLOS_POR_BIT);
    localparam int BW = $clog2(BITS_DADOS);
    localparam logic [CW-1:0] CNT_MEIO   = CW'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FIM    = CW'(CICLOS_POR_BIT - 1);
    localparam logic [BW-1:0] BIT_ULTIMO = BW'(BITS_DADOS - 1);

    logic                  rx_s;
    estado_t               estado, prox_estado;
    logic [CW-1:0]         cnt_ciclo;
    logic [BW-1:0]         cnt_bit;
    logic [BITS_DADOS-1:0] desloc;
    logic                  par_hold;
    logic                  limpa_cnt, desloca, captura_par, fim_quadro;

`ifdef RX_SINCRONIZADOR_EN
    sincronizador_rx u_sinc (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    always_ff @(posedge clk) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:   if (!rx_s) prox_estado = INICIO;
            INICIO:   if (cnt_ciclo == CNT_MEIO) prox_estado = rx_s ? OCIOSO : DADOS;
            DADOS:    if (cnt_ciclo == CNT_FIM && cnt_bit == BIT_ULTIMO) prox_estado = PARIDADE;
            PARIDADE: if (cnt_ciclo == CNT_FIM) prox_estado = PARADA;
            PARADA:   if (cnt_ciclo == CNT_FIM) prox_estado = OCIOSO;
            default:  prox_estado = OCIOSO;
        endcase
    end

    // Counter restarts at mid-start so every later sample lands mid-bit.
    always_comb begin
        limpa_cnt   = 1'b0;
        desloca     = 1'b0;
        captura_par = 1'b0;
        fim_quadro  = 1'b0;
        ocupado     = (estado != OCIOSO);
        case (estado)
            OCIOSO:   limpa_cnt = 1'b1;
            INICIO:   limpa_cnt = (cnt_ciclo == CNT_MEIO);
            DADOS: begin
                limpa_cnt = (cnt_ciclo == CNT_FIM);
                desloca   = (cnt_ciclo == CNT_FIM);
            end
            PARIDADE: begin
                limpa_cnt   = (cnt_ciclo == CNT_FIM);
                captura_par = (cnt_ciclo == CNT_FIM);
            end
            PARADA: begin
                limpa_cnt  = (cnt_ciclo == CNT_FIM);
                fim_quadro = (cnt_ciclo == CNT_FIM);
            end
            default:  limpa_cnt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ciclo    <= '0;
            cnt_bit      <= '0;
            desloc       <= '0;
            par_hold     <= 1'b0;
            dados        <= '0;
            bit_paridade <= 1'b1;
            valido       <= 1'b0;
            erro_quadro  <= 1'b0;
        end else begin
            cnt_ciclo <= limpa_cnt ? '0 : cnt_ciclo + CW'(1);
            if (desloca)
                cnt_bit <= cnt_bit + BW'(1);
            else if (estado != DADOS)
                cnt_bit <= '0;
            if (desloca)
                desloc <= {rx_s, desloc[BITS_DADOS-1:1]};
            if (captura_par)
                par_hold <= rx_s;
            valido      <= fim_quadro &  rx_s;
            erro_quadro <= fim_quadro & ~rx_s;
            if (fim_quadro && rx_s) begin
                dados        <= desloc;
                bit_paridade <= par_hold;
            end
        end
    end

endmodule

// File: tb/tb_receptor_serial_paridade.sv
// Bench for receptor_serial_paridade: serial frames driven on negedge, expected
// results queued per frame and compared when valido/erro_quadro pulses.
module tb_receptor_serial_paridade;

    localparam int N = 16;
`ifdef RX_SINCRONIZADOR_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] dados;
    logic       bit_paridade, valido, erro_quadro, ocupado;

    receptor_serial_paridade #(.CICLOS_POR_BIT(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .dados        (dados),
        .bit_paridade (bit_paridade),
        .valido       (valido),
        .erro_quadro  (erro_quadro),
        .ocupado      (ocupado)
    );

    always #5 clk = ~clk;

    int ciclos = 0;
    always @(posedge clk) ciclos <= ciclos + 1;

    typedef struct {
        logic       erro;
        logic [7:0] dados;
        logic       par;
        logic       chk;
        int         ciclo;
    } esp_t;

    esp_t       fila[$];
    logic [7:0] ref_dados = 8'h00;
    logic       ref_par = 1'b1;
    int         n_checks = 0;
    int         n_erros = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic verifica_reset(input string tag);
        verifica({tag, "_dados"}, {24'b0, dados}, 32'h00);
        verifica({tag, "_par"}, {31'b0, bit_paridade}, 32'h1);
        verifica({tag, "_valido"}, {31'b0, valido}, 32'h0);
        verifica({tag, "_erro_quadro"}, {31'b0, erro_quadro}, 32'h0);
        verifica({tag, "_ocupado"}, {31'b0, ocupado}, 32'h0);
    endtask

    // Frame bits: index 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    task automatic envia_quadro(input logic [7:0] b, input logic p, input logic s, input int aborta);
        logic [10:0] q;
        esp_t        e;
        q = {s, p, b, 1'b0};
        if (aborta < 0) begin
            if (s) begin
                ref_dados = b;
                ref_par   = p;
            end
            e.erro  = ~s;
            e.dados = ref_dados;
            e.par   = ref_par;
            e.chk   = ~^{ref_dados, ref_par};
            e.ciclo = ciclos + 1 + LAT + N / 2 + 10 * N;
            fila.push_back(e);
        end
        for (int i = 0; i < 11; i++) begin
            if (i == aborta) begin
                reset = 1'b1;
                @(negedge clk);
                verifica_reset("reset_meio");
                reset = 1'b0;
                rx = 1'b1;
                ref_dados = 8'h00;
                ref_par   = 1'b1;
                return;
            end
            rx = q[i];
            repeat (N) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (valido || erro_quadro) begin
            verifica("exclusivo", {31'b0, valido & erro_quadro}, 32'h0);
            if (fila.size() == 0) begin
                verifica("pulso_inesperado", 32'h1, 32'h0);
            end else begin
                esp_t e;
                e = fila.pop_front();
                verifica("tipo", {31'b0, erro_quadro}, {31'b0, e.erro});
                verifica("dados", {24'b0, dados}, {24'b0, e.dados});
                verifica("paridade", {31'b0, bit_paridade}, {31'b0, e.par});
                verifica("checker_erro", {31'b0, ~^{dados, bit_paridade}}, {31'b0, e.chk});
                verifica("instante", ciclos, e.ciclo);
            end
        end
    end

    initial begin
        int n_ocupado;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        verifica_reset("inicio");
        reset = 1'b0;
        repeat (N) @(negedge clk);

        envia_quadro(8'h01, 1'b0, 1'b1, -1);
        envia_quadro(8'h00, 1'b0, 1'b1, -1);
        envia_quadro(8'hA5, 1'b1, 1'b0, -1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);

        n_ocupado = 0;
        for (int i = 0; i < 3 * N; i++) begin
            if (i == 0) rx = 1'b0;
            if (i == 4) rx = 1'b1;
            @(negedge clk);
            if (ocupado) n_ocupado++;
        end
        verifica("glitch_ocupado", n_ocupado, N / 2);
        verifica("glitch_fila", fila.size(), 0);

        envia_quadro(8'hFF, 1'b1, 1'b1, -1);
        envia_quadro(8'h7F, 1'b0, 1'b1, -1);
        rx = 1'b1;
        repeat (N) @(negedge clk);

        envia_quadro(8'h3C, 1'b1, 1'b1, 4);
        repeat (12 * N) @(negedge clk);
        verifica("pos_reset_ocupado", {31'b0, ocupado}, 32'h0);
        envia_quadro(8'h3C, 1'b1, 1'b1, -1);
        rx = 1'b1;
        repeat (N) @(negedge clk);

        verifica("pendentes", fila.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_erros, n_checks);
        $finish;
    end

endmodule
